data_mem: RTL and testbench

- Word-organised data memory directly downstream of the ALU in the P4 single-cycle datapath.
- Consumes the ALU result `r` as the byte address and the rt register value as store data.
- Performs byte/half/word stores with byte lanes, and combinational loads with sign/zero extension.
- Records misaligned and out-of-range accesses in sticky error flags for the controller and bench.

---
 rtl/mips_pkg.sv | 17 +
 rtl/load_ext.sv | 30 +++
 rtl/data_mem.sv | 148 ++++++++++++++
 tb/tb_data_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the P4 datapath: access size encodings, the
// error-history bit positions used by data_mem, and the default data base.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;

  localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/load_ext.sv
// Lane extraction plus sign/zero extension for loads. Purely combinational so
// the same block can sit in the pipelined MEM stage later.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // Pick the lane(s) for the access size and extend; reserved size yields zero.
  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory behind the ALU. Byte/half/word stores with lane
// enables, combinational extended loads, and sticky {range, align} error bits.
// Optional store trace: define DM_TRACE_EN to print one line per committed store.
module data_mem
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = DM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        out_of_range,
  output logic [1:0]  err_sticky
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];
  logic [1:0]  r_errSticky;

  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_access;
  logic                  w_badAlign;
  logic                  w_misalign;
  logic                  w_outOfRange;
  logic                  w_commit;
  logic [3:0]            w_byteEn;
  logic [31:0]           w_laneData;
  logic [31:0]           w_rawWord;
  logic [31:0]           w_merged;
  logic [31:0]           w_extData;

  // Addresses below the base wrap to huge offsets and land in the range check.
  assign w_off        = addr - BASE_ADDR;
  assign w_idx        = w_off[ADDR_WIDTH+1:2];
  assign w_lane       = w_off[1:0];
  assign w_access     = we | re;
  assign w_outOfRange = w_access & (w_off[31:ADDR_WIDTH+2] != '0);
  assign w_misalign   = w_access & w_badAlign;
  assign w_commit     = we & ~w_misalign & ~w_outOfRange;
  assign w_rawWord    = r_mem[w_idx];

  // Alignment rule per access size; the reserved encoding is always illegal.
  always_comb begin
    w_badAlign = 1'b0;
    case (size)
      SZ_HALF: w_badAlign = w_lane[0];
      SZ_WORD: w_badAlign = |w_lane;
      SZ_RSVD: w_badAlign = 1'b1;
      default: w_badAlign = 1'b0;
    endcase
  end

  // Byte enables and replicated store data so each lane sees its own bytes.
  always_comb begin
    w_byteEn   = 4'b0000;
    w_laneData = '0;
    case (size)
      SZ_BYTE: begin
        w_byteEn   = 4'b0001 << w_lane;
        w_laneData = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_byteEn   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_laneData = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        w_byteEn   = 4'b1111;
        w_laneData = wdata;
      end
      default: begin
        w_byteEn   = 4'b0000;
        w_laneData = '0;
      end
    endcase
  end

  // Full word after the lane merge; this is what gets written and traced.
  always_comb begin
    w_merged = w_rawWord;
    for (int b = 0; b < 4; b++) begin
      if (w_byteEn[b]) begin
        w_merged[8*b +: 8] = w_laneData[8*b +: 8];
      end
    end
  end

  // Array write; reset clears every word so an in-flight store is discarded whole.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Error history only accumulates; nothing but reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errSticky <= 2'b00;
    end else begin
      r_errSticky[ERR_ALIGN] <= r_errSticky[ERR_ALIGN] | w_misalign;
      r_errSticky[ERR_RANGE] <= r_errSticky[ERR_RANGE] | w_outOfRange;
    end
  end

  load_ext u_loadExt (
    .i_word     (w_rawWord),
    .i_lane     (w_lane),
    .i_size     (size),
    .i_unsigned (ld_unsigned),
    .o_data     (w_extData)
  );

  assign rdata        = (w_outOfRange | w_misalign) ? 32'h0 : w_extData;
  assign misalign     = w_misalign;
  assign out_of_range = w_outOfRange;
  assign err_sticky   = r_errSticky;

`ifdef DM_TRACE_EN
  logic [31:0] w_wordByteAddr;
  assign w_wordByteAddr = BASE_ADDR + {{(30-ADDR_WIDTH){1'b0}}, w_idx, 2'b00};

  // One log line per committed store, in the grading log format.
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      $display("%d@%h: *%h <= %h", $time, pc, w_wordByteAddr, w_merged);
    end
  end
`else
  logic [31:0] w_unusedPc;
  assign w_unusedPc = pc;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset state, word and lane
// loads/stores, read-during-write, alignment and range errors, back-to-back
// stores, and an asynchronous reset landing in the middle of a store cycle.
module tb_data_mem;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] rdata;
  logic        misalign;
  logic        out_of_range;
  logic [1:0]  err_sticky;

  int errors = 0;
  int checks = 0;

  data_mem dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .addr         (addr),
    .wdata        (wdata),
    .we           (we),
    .re           (re),
    .size         (size),
    .ld_unsigned  (ld_unsigned),
    .rdata        (rdata),
    .misalign     (misalign),
    .out_of_range (out_of_range),
    .err_sticky   (err_sticky)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access just after the falling edge so it settles well before the next rising edge.
  task automatic applyStimulus(input logic iWe, input logic iRe, input logic [1:0] iSize,
                               input logic iUns, input logic [31:0] iAddr, input logic [31:0] iWdata);
    @(negedge clk);
    we          = iWe;
    re          = iRe;
    size        = iSize;
    ld_unsigned = iUns;
    addr        = iAddr;
    wdata       = iWdata;
    pc          = pc + 32'd4;
    #1;
  endtask

  // Reset holds the array and error history at zero; first load after release sees zeros.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_sticky !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_during: got %b, expected 00", err_sticky); end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_load0: got %h, expected 00000000", rdata); end
    checks++; if (err_sticky !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 00", err_sticky); end
    checks++; if (misalign !== 1'b0 || out_of_range !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b, expected 00", misalign, out_of_range); end
  endtask

  // Word store then word load at the same address.
  task automatic test_word();
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h8765_4321);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h8765_4321) begin errors++; $display("[TB] FAIL word_load: got %h, expected 87654321", rdata); end
  endtask

  // Lane extraction with sign and zero extension from 0x8765_4321.
  task automatic test_lanes();
    applyStimulus(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    checks++; if (rdata !== 32'hFFFF_FF87) begin errors++; $display("[TB] FAIL lb_13: got %h, expected ffffff87", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    checks++; if (rdata !== 32'h0000_0087) begin errors++; $display("[TB] FAIL lbu_13: got %h, expected 00000087", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h0000_4321) begin errors++; $display("[TB] FAIL lh_10: got %h, expected 00004321", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0);
    checks++; if (rdata !== 32'hFFFF_8765) begin errors++; $display("[TB] FAIL lh_12: got %h, expected ffff8765", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_BYTE, 1'b1, 32'h11, 32'h0);
    checks++; if (rdata !== 32'h0000_0043) begin errors++; $display("[TB] FAIL lbu_11: got %h, expected 00000043", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b1, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h8765_4321) begin errors++; $display("[TB] FAIL lwu_10: got %h, expected 87654321", rdata); end
  endtask

  // Partial stores merge into the existing word; a load in the store cycle sees old data first.
  task automatic test_partial_stores();
    applyStimulus(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_00AB);
    checks++; if (rdata !== 32'h0000_0065) begin errors++; $display("[TB] FAIL rdw_old: got %h, expected 00000065", rdata); end
    @(posedge clk); #1;
    checks++; if (rdata !== 32'hFFFF_FFAB) begin errors++; $display("[TB] FAIL rdw_new: got %h, expected ffffffab", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h87AB_4321) begin errors++; $display("[TB] FAIL sb_merge: got %h, expected 87ab4321", rdata); end
    applyStimulus(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h1234_BEEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h87AB_BEEF) begin errors++; $display("[TB] FAIL sh_merge: got %h, expected 87abbeef", rdata); end
  endtask

  // Misaligned accesses are blocked, zero the load data, and set the align sticky bit.
  task automatic test_misalign();
    applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0);
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL misalign_idle: got %b, expected 0", misalign); end
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'hDEAD_BEEF);
    checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL misalign_sw: got %b, expected 1", misalign); end
    checks++; if (err_sticky !== 2'b00) begin errors++; $display("[TB] FAIL err_before: got %b, expected 00", err_sticky); end
    @(posedge clk); #1;
    checks++; if (err_sticky !== 2'b01) begin errors++; $display("[TB] FAIL err_align: got %b, expected 01", err_sticky); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL misalign_nowrite: got %h, expected 00000000", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0);
    checks++; if (rdata !== 32'h0 || misalign !== 1'b1) begin errors++; $display("[TB] FAIL lh_21: got %h/%b, expected 00000000/1", rdata, misalign); end
    applyStimulus(1'b0, 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h0 || misalign !== 1'b1) begin errors++; $display("[TB] FAIL size_rsvd: got %h/%b, expected 00000000/1", rdata, misalign); end
  endtask

  // Range check at the top of the 4 KiB array and for addresses that wrap below the base.
  task automatic test_range();
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h1111_2222);
    checks++; if (out_of_range !== 1'b1) begin errors++; $display("[TB] FAIL oor_1000: got %b, expected 1", out_of_range); end
    @(posedge clk); #1;
    checks++; if (err_sticky !== 2'b11) begin errors++; $display("[TB] FAIL err_range: got %b, expected 11", err_sticky); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_alias: got %h, expected 00000000", rdata); end
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'hCAFE_F00D);
    checks++; if (out_of_range !== 1'b0) begin errors++; $display("[TB] FAIL oor_ffc: got %b, expected 0", out_of_range); end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'h0);
    checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL load_ffc: got %h, expected cafef00d", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0);
    checks++; if (out_of_range !== 1'b1 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_wrap: got %b/%h, expected 1/00000000", out_of_range, rdata); end
  endtask

  // Stores on consecutive edges both land.
  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'hA5A5_0001);
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h5A5A_0002);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0);
    checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL b2b_40: got %h, expected a5a50001", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h0);
    checks++; if (rdata !== 32'h5A5A_0002) begin errors++; $display("[TB] FAIL b2b_44: got %h, expected 5a5a0002", rdata); end
  endtask

  // Reset arriving between edges clears everything at once and swallows the pending store.
  task automatic test_reset_midcycle();
    applyStimulus(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_clear: got %h, expected 00000000", rdata); end
    checks++; if (err_sticky !== 2'b00) begin errors++; $display("[TB] FAIL midrst_err: got %b, expected 00", err_sticky); end
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_edge: got %h, expected 00000000", rdata); end
    @(negedge clk);
    we    = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_after: got %h, expected 00000000", rdata); end
    applyStimulus(1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_ffc: got %h, expected 00000000", rdata); end
  endtask

  // Run every scenario in order, then print the one summary line.
  initial begin
    reset       = 1'b1;
    pc          = 32'h0040_0000;
    addr        = '0;
    wdata       = '0;
    we          = 1'b0;
    re          = 1'b0;
    size        = SZ_WORD;
    ld_unsigned = 1'b0;
    test_reset();
    test_word();
    test_lanes();
    test_partial_stores();
    test_misalign();
    test_range();
    test_back_to_back();
    test_reset_midcycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
